pwm_job_scheduler: RTL
======================

Name: pwm_job_scheduler

Overview:
- Sits between the SPI register interface and the four PWM generator channels.
- Accepts (channel, duty, final-value) jobs, buffers them in a per-channel FIFO, and dispatches each job to its channel with a one-cycle start pulse.
- Waits for the channel's done pulse before issuing the next job on that channel.
- Turns the PWM bank into a queued, back-to-back job engine.

Parameters:
- NCH, 4: number of PWM channels; channel index width is 2.
- DEPTH, 4: entries per channel FIFO; power of 2, at least 2.
- DUTY_W, 8: duty field width.
- FV_W, 15: final-value (timer terminal count) width.
- TIMEOUT_CYC, 1048576: watchdog limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  job offered this cycle.
- i_cmd_chan  in  2  target channel.
- i_cmd_duty  in  DUTY_W  duty for the job.
- i_cmd_final  in  FV_W  final value for the job.
- o_cmd_ready  out  1  job is accepted when valid && ready.
- i_flush  in  NCH  per-channel flush, level-sampled.
- i_done  in  NCH  per-channel one-cycle job-complete pulse from the PWM channel.
- o_start  out  NCH  per-channel one-cycle dispatch pulse; drives the PWM channel's ready input.
- o_duty  out  NCH*DUTY_W  packed per-channel duty; channel k is at bits [k*DUTY_W +: DUTY_W].
- o_final  out  NCH*FV_W  packed per-channel final value, same packing rule.
- o_busy  out  NCH  channel in RUN state.
- o_level  out  NCH*3  per-channel FIFO occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a job was offered while not ready.
- o_timeout  out  NCH  sticky per-channel watchdog flag.

Behaviour:
- Reset: asynchronous and active-low on reset_n, single clock clk. All FIFOs are emptied. Every channel goes to IDLE. o_start=0, o_duty=0, o_final=0, o_busy=0, o_level=0, o_overflow=0, o_timeout=0.
- Accept:
  - o_cmd_ready = ~full[i_cmd_chan] && ~i_flush[i_cmd_chan]. This is combinational from the channel select.
  - On a rising edge with valid && ready, the job is pushed into FIFO[chan].
  - A job with i_cmd_final==0 is accepted (ready honoured) but discarded, not pushed.
  - valid && ~ready sets o_overflow; the job is dropped. o_overflow clears only on reset.
- Per-channel FSM, states IDLE and RUN:
  - IDLE with FIFO non-empty: on the next edge, pop the head, register o_duty/o_final for that channel, pulse o_start for exactly one cycle, and enter RUN.
  - RUN: hold o_duty/o_final stable. On i_done, return to IDLE at that edge.
  - i_done seen in IDLE is ignored.
- Latency:
  - A job pushed at edge E0 into an empty FIFO of an idle channel gives o_start high after edge E0+1.
  - i_done at edge Ed with a queued job gives o_start high after edge Ed+1. Throughput is one job per 2 cycles minimum.
- Simultaneous push and pop on one FIFO: both happen; the level is unchanged.
  - Push into an empty FIFO is not bypassed to dispatch in the same cycle.
  - ready is based on full only, so a full FIFO refuses a push even while popping.
- Channels are fully independent. There is no arbitration, because each channel has its own FIFO and output bus.
- Flush:
  - i_flush[k] high at an edge empties FIFO k, forces channel k to IDLE, and suppresses o_start[k] that cycle.
  - o_duty/o_final hold their last values.
  - A flush overrides a simultaneous push to that channel; ready is already low.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate counter saturating at DEPTH.

Optional Feature:
- Macro: PWM_SCHED_TIMEOUT_EN.
- Defined:
  - A per-channel counter clears on dispatch and increments each cycle in RUN.
  - Reaching TIMEOUT_CYC-1 forces the channel to IDLE, sets o_timeout[k], and lets the next job dispatch normally.
  - i_done in the same cycle as the timeout takes priority: the channel returns to IDLE and o_timeout is not set.
- Not defined: no counters are built; o_timeout is tied to 0.

Test Plan:
1. Reset, then push ch0 duty=0x40 final=100 at edge E0 -> o_start[0] high for one cycle after E0+1, o_duty[7:0]=0x40, o_final[14:0]=100, o_busy[0]=1; o_busy[0]=0 after i_done[0].
2. Push 5 jobs to ch2 back-to-back with no done -> first dispatched, next 4 fill the FIFO, o_level ch2=4, o_cmd_ready low for ch2. A 6th offer sets o_overflow=1. Pulsing i_done[2] four times yields 4 further o_start[2] pulses, in order, each one cycle after its done.
3. Jobs to all four channels in consecutive cycles -> each o_start[k] fires independently with correct packed fields; no cross-channel corruption.
4. Job with final=0 on ch1 -> accepted, o_level unchanged, no o_start[1].
5. Ch3 in RUN with 2 queued, assert i_flush[3] one cycle -> o_level ch3=0, o_busy[3]=0, no o_start[3], o_duty ch3 unchanged.
6. With PWM_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: dispatch ch0 with no done -> after 16 cycles o_busy[0]=0 and o_timeout[0]=1. Repeat with i_done[0] on the timeout cycle -> o_timeout stays 0.

Source files
------------

// File: rtl/pwm_job_scheduler_if.sv
// Job command channel into pwm_job_scheduler: a valid/ready handshake carrying
// (channel, duty, final-value).
interface pwm_job_scheduler_if #(
  parameter int NCH    = 4,
  parameter int DUTY_W = 8,
  parameter int FV_W   = 15
) ();
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              i_cmd_valid;
  logic [CH_W-1:0]   i_cmd_chan;
  logic [DUTY_W-1:0] i_cmd_duty;
  logic [FV_W-1:0]   i_cmd_final;
  logic              o_cmd_ready;

  modport master (
    output i_cmd_valid, i_cmd_chan, i_cmd_duty, i_cmd_final,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd_chan, i_cmd_duty, i_cmd_final,
    output o_cmd_ready
  );
endinterface

// File: rtl/pwm_job_scheduler.sv
// Per-channel job FIFOs feeding the PWM bank; each channel dispatches one job at a time.
// Optional watchdog per channel is built only when PWM_SCHED_TIMEOUT_EN is defined.
module pwm_job_scheduler #(
  parameter int NCH         = 4,
  parameter int DEPTH       = 4,
  parameter int DUTY_W      = 8,
  parameter int FV_W        = 15,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pwm_job_scheduler_if.slave    cmd_if,
  input  logic [NCH-1:0]        i_flush,
  input  logic [NCH-1:0]        i_done,
  output logic [NCH-1:0]        o_start,
  output logic [NCH*DUTY_W-1:0] o_duty,
  output logic [NCH*FV_W-1:0]   o_final,
  output logic [NCH-1:0]        o_busy,
  output logic [NCH*3-1:0]      o_level,
  output logic                  o_overflow,
  output logic [NCH-1:0]        o_timeout
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [NCH-1:0] w_full;
  logic           w_ready;
  logic           w_final_nz;
  logic           r_overflow;

  // Ready looks only at the addressed channel; a full FIFO refuses even while it pops.
  assign w_ready            = ~w_full[cmd_if.i_cmd_chan] & ~i_flush[cmd_if.i_cmd_chan];
  assign w_final_nz         = |cmd_if.i_cmd_final;
  assign cmd_if.o_cmd_ready = w_ready;
  assign o_overflow         = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (cmd_if.i_cmd_valid && !w_ready) begin
      r_overflow <= 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_tmo_hit;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [DUTY_W-1:0] r_mem_duty  [DEPTH];
    logic [FV_W-1:0]   r_mem_final [DEPTH];
    logic              r_start;
    logic [DUTY_W-1:0] r_duty;
    logic [FV_W-1:0]   r_final;

    // Zero-length jobs complete the handshake but never occupy the FIFO.
    assign w_push = cmd_if.i_cmd_valid & w_ready & w_final_nz &
                    (cmd_if.i_cmd_chan == CH_W'(k));

    always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_level != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (i_done[k] || w_tmo_hit) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (i_flush[k]) begin
        w_pop       = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else if (i_flush[k]) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop) begin
          r_level <= r_level + 1'b1;
        end else if (!w_push && w_pop) begin
          r_level <= r_level - 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem_duty[r_wptr]  <= cmd_if.i_cmd_duty;
        r_mem_final[r_wptr] <= cmd_if.i_cmd_final;
      end
    end

    // Dispatch registers: duty/final hold through RUN and survive a flush.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_start <= 1'b0;
        r_duty  <= '0;
        r_final <= '0;
      end else begin
        r_start <= w_pop;
        if (w_pop) begin
          r_duty  <= r_mem_duty[r_rptr];
          r_final <= r_mem_final[r_rptr];
        end
      end
    end

`ifdef PWM_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    // A done pulse or flush on the terminal cycle wins over the watchdog.
    assign w_tmo_hit = (r_state == S_RUN) & (r_tmo_cnt == TMO_LAST) & ~i_done[k] & ~i_flush[k];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_tmo_cnt <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_pop) begin
          r_tmo_cnt <= '0;
        end else if (r_state == S_RUN) begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
        if (w_tmo_hit) r_timeout <= 1'b1;
      end
    end

    assign o_timeout[k] = r_timeout;
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign w_tmo_hit        = 1'b0;
    assign o_timeout[k]     = 1'b0;
`endif

    assign w_full[k]                   = (r_level == LVL_FULL);
    assign o_start[k]                  = r_start;
    assign o_busy[k]                   = (r_state == S_RUN);
    assign o_duty[k*DUTY_W +: DUTY_W]  = r_duty;
    assign o_final[k*FV_W +: FV_W]     = r_final;
    assign o_level[k*3 +: 3]           = 3'(r_level);
  end

endmodule
